// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done handshake and operand/result bundle for serial_subtractor
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             in_start;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_bi;
  logic             out_busy;
  logic             out_done;
  logic [WIDTH-1:0] out_d;
  logic             out_bo;

  modport master (
    output in_start, in_a, in_b, in_bi,
    input  out_busy, out_done, out_d, out_bo
  );

  modport slave (
    input  in_start, in_a, in_b, in_bi,
    output out_busy, out_done, out_d, out_bo
  );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - Bin, LSB first, one full-subtractor cell and a borrow flop
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input logic              in_clk,
  input logic              in_rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bo_q, bo_d;

  logic             a0, b0, d_bit, br_next, cnt_last;
  logic [WIDTH-1:0] r_shift;

  assign a0       = a_q[0];
  assign b0       = b_q[0];
  assign d_bit    = a0 ^ b0 ^ br_q;
  assign br_next  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
  assign cnt_last = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bo_d    = bo_q;
    // Result register fills from the MSB so after WIDTH shifts bit 0 lands at index 0.
    r_shift            = r_q >> 1;
    r_shift[WIDTH-1]   = d_bit;

    case (state_q)
      IDLE: begin
        if (bus.in_start) begin
          state_d = SHIFT;
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          br_d    = bus.in_bi;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        r_d   = r_shift;
        br_d  = br_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_last) begin
          state_d = DONE;
          d_d     = r_shift;
          bo_d    = br_next;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
    end
  end

  assign bus.out_busy = (state_q == SHIFT);
  assign bus.out_done = (state_q == DONE);
  assign bus.out_d    = d_q;
  assign bus.out_bo   = bo_q;
endmodule
